// File: rtl/dm_bus_slave.sv
// Word-organised data memory that answers memory-stage load/store requests
// after WAIT wait cycles, and zero-fills its array with a sweep after every reset.
module dm_bus_slave #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned WORDS = 1 << IDX_W;

  typedef enum logic [1:0] {ST_CLR, ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0]      mem [WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      cur_word;
  logic [31:0]      merged_word;
  logic             req_err;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic             unused_addr_bits;

  assign idx              = addr_q[ADDR_W-1:2];
  assign cur_word         = mem[idx];
  assign unused_addr_bits = ^addr_q[1:0];
  // Any address bit above the array, or a store with no lanes enabled, is rejected.
  assign req_err = ((addr_q >> ADDR_W) != 32'd0) || (we_q && (be_q == 4'b0000));

  always_comb begin
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    case (state_q)
      ST_CLR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {IDX_W{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req) begin
          we_d       = we;
          addr_d     = addr;
          be_d       = be;
          wdata_d    = wdata;
          wait_cnt_d = 4'(WAIT);
          state_d    = (WAIT == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd1) state_d = ST_RESP;
        else wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_RESP: begin
        ready_d = 1'b1;
        err_d   = req_err;
        rdata_d = req_err ? 32'd0 : cur_word;
        state_d = ST_IDLE;
      end
      default: state_d = ST_CLR;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // The sweep and the response share one write port; they never overlap in time.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = clr_cnt_q;
    mem_wdata = 32'd0;
    if (state_q == ST_CLR) begin
      mem_we = 1'b1;
    end else if ((state_q == ST_RESP) && we_q && !req_err) begin
      mem_we    = 1'b1;
      mem_idx   = idx;
      mem_wdata = merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CLR;
      clr_cnt_q  <= '0;
      wait_cnt_q <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b1;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_dm_bus_slave.sv
// Self-checking bench for dm_bus_slave: a WAIT=2 instance checked against an
// array-based memory model, plus a WAIT=0 instance for the zero-wait timing.
module tb_dm_bus_slave;
  localparam int TW    = 2;
  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, req0 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  be = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready, err, busy, ready0, err0, busy0;
  logic [31:0] rdata, rdata0;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [WORDS];

  dm_bus_slave #(.ADDR_W(12), .WAIT(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .ready(ready), .rdata(rdata), .err(err), .busy(busy)
  );

  dm_bus_slave #(.ADDR_W(12), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one transaction on a 1024-word, 4 KiB array.
  function automatic void model_access(input logic mwe, input logic [31:0] maddr,
                                       input logic [3:0] mbe, input logic [31:0] mwd,
                                       output logic [31:0] mrd, output logic merr);
    int w;
    merr = (maddr >= 32'h1000) || (mwe && mbe == 4'd0);
    w = int'(maddr / 4) % WORDS;
    if (merr) begin
      mrd = 32'd0;
    end else begin
      mrd = ref_mem[w];
      if (mwe) begin
        for (int b = 0; b < 4; b++)
          if (mbe[b]) ref_mem[w][8*b +: 8] = mwd[8*b +: 8];
      end
    end
  endfunction

  task automatic clear_model();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    @(negedge clk);
    while (busy !== 1'b0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s idle_wait: busy=%0b required 0", tag, busy);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] slave never became idle");
    end
  endtask

  task automatic txn(input logic twe, input logic [31:0] taddr, input logic [3:0] tbe,
                     input logic [31:0] twd, input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    wait_idle(tag);
    model_access(twe, taddr, tbe, twd, exp_rd, exp_err);
    req = 1'b1; we = twe; addr = taddr; be = tbe; wdata = twd;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s accept: busy=%0b required 1", tag, busy);
    end
    for (int k = 1; k <= TW + 1; k++) begin
      @(negedge clk);
      checks++;
      if (k <= TW) begin
        if (ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s early_ready at E0+%0d: ready=%0b required 0", tag, k, ready);
        end
      end else if (ready !== 1'b1 || err !== exp_err || rdata !== exp_rd) begin
        errors++;
        $display("[TB] FAIL %s response: ready=%0b err=%0b rdata=%h required ready=1 err=%0b rdata=%h",
                 tag, ready, err, rdata, exp_err, exp_rd);
      end
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || err !== 1'b0 || rdata !== exp_rd) begin
      errors++;
      $display("[TB] FAIL %s after_pulse: ready=%0b err=%0b rdata=%h required ready=0 err=0 rdata=%h",
               tag, ready, err, rdata, exp_rd);
    end
  endtask

  // Releases reset at the current negedge and measures the clearing sweep.
  task automatic do_sweep(input string tag);
    int  cnt = 0;
    bit  seen = 0;
    reset = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h40; be = 4'hF; wdata = 32'hA5A5A5A5;
    while (cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 8) req = 1'b0;
      if (ready === 1'b1 || ready0 === 1'b1) seen = 1;
      if (busy !== 1'b1) break;
    end
    checks++;
    if (cnt != WORDS) begin
      errors++;
      $display("[TB] FAIL %s sweep_len: busy cycles=%0d required %0d", tag, cnt, WORDS);
    end
    checks++;
    if (seen || busy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s sweep_quiet: ready_seen=%0b busy0=%0b required 0 0", tag, seen, busy0);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || err !== 1'b0 || rdata !== 32'd0 || busy0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_values: busy=%0b ready=%0b err=%0b rdata=%h busy0=%0b required 1 0 0 0 1",
               busy, ready, err, rdata, busy0);
    end
    do_sweep("reset");
    txn(1'b0, 32'h0000_0FFC, 4'h0, 32'd0, "load_top_word");
  endtask

  task automatic test_store_load();
    txn(1'b1, 32'h40, 4'b1111, 32'h12345678, "store_word");
    txn(1'b0, 32'h40, 4'b0000, 32'd0, "load_word");
    txn(1'b1, 32'h40, 4'b0010, 32'h0000AB00, "store_byte1");
    txn(1'b0, 32'h43, 4'b1111, 32'd0, "load_merged");
    txn(1'b0, 32'h44, 4'b0000, 32'd0, "load_neighbour");
  endtask

  task automatic test_error();
    txn(1'b0, 32'h1000, 4'h0, 32'd0, "load_oob");
    txn(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, "store_oob");
    txn(1'b0, 32'h0, 4'h0, 32'd0, "load_word0");
    txn(1'b1, 32'h44, 4'h0, 32'h11111111, "store_no_lanes");
    txn(1'b0, 32'h44, 4'h0, 32'd0, "load_after_no_lanes");
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd1, rd2;
    logic        e1, e2;
    wait_idle("b2b");
    model_access(1'b1, 32'h200, 4'hF, 32'hCAFEF00D, rd1, e1);
    model_access(1'b0, 32'h200, 4'h0, 32'd0, rd2, e2);
    req = 1'b1; we = 1'b1; addr = 32'h200; be = 4'hF; wdata = 32'hCAFEF00D;
    for (int k = 0; k <= 2 * TW + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        we = 1'b0; be = 4'h0; wdata = 32'd0;
      end
      if (k == TW + 2) req = 1'b0;
      if (k >= 1) begin
        checks++;
        if (k == TW + 1) begin
          if (ready !== 1'b1 || err !== e1 || rdata !== rd1) begin
            errors++;
            $display("[TB] FAIL b2b first: ready=%0b err=%0b rdata=%h required 1 %0b %h", ready, err, rdata, e1, rd1);
          end
        end else if (k == 2 * TW + 3) begin
          if (ready !== 1'b1 || err !== e2 || rdata !== rd2) begin
            errors++;
            $display("[TB] FAIL b2b second: ready=%0b err=%0b rdata=%h required 1 %0b %h", ready, err, rdata, e2, rd2);
          end
        end else if (ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b gap at E0+%0d: ready=%0b required 0", k, ready);
        end
      end
    end
  endtask

  task automatic test_random();
    logic        rwe;
    logic [31:0] raddr;
    logic [3:0]  rbe;
    int          sel;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) raddr = $urandom | 32'h0001_0000;
      else if (sel == 1) raddr = 32'h1000 + 32'($urandom_range(0, 255));
      else raddr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      rwe = 1'($urandom_range(0, 1));
      rbe = 4'($urandom_range(0, 15));
      txn(rwe, raddr, rbe, $urandom, "random");
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen = 0;
    wait_idle("abort");
    req = 1'b1; we = 1'b1; addr = 32'h80; be = 4'hF; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_reset_values: busy=%0b ready=%0b rdata=%h err=%0b required 1 0 0 0",
               busy, ready, rdata, err);
    end
    clear_model();
    repeat (3) begin
      @(negedge clk);
      if (ready === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL abort_no_ready: ready_seen=1 required 0");
    end
    do_sweep("abort");
    txn(1'b0, 32'h80, 4'h0, 32'd0, "load_after_abort");
  endtask

  task automatic test_wait0();
    @(negedge clk);
    req0 = 1'b1; we = 1'b1; addr = 32'h100; be = 4'hF; wdata = 32'h5A5AC3C3;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        we = 1'b0; be = 4'h0; wdata = 32'd0;
      end
      if (k == 2) req0 = 1'b0;
      if (k >= 1) begin
        checks++;
        if (k == 1) begin
          if (ready0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL wait0 store: ready=%0b err=%0b rdata=%h required 1 0 00000000", ready0, err0, rdata0);
          end
        end else if (k == 3) begin
          if (ready0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'h5A5AC3C3) begin
            errors++;
            $display("[TB] FAIL wait0 load: ready=%0b err=%0b rdata=%h required 1 0 5a5ac3c3", ready0, err0, rdata0);
          end
        end else if (ready0 !== 1'b0) begin
          errors++;
          $display("[TB] FAIL wait0 gap at E0+%0d: ready=%0b required 0", k, ready0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_error();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    test_wait0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
